// File: rtl/core_boot_ctrl_pkg.sv
// Shared definitions for the boot/run sequencer: sequencer states, the
// machine word width shared with the core and memories, and the byte stride
// of one instruction word.
package core_boot_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/core_boot_ctrl_if.sv
// Loader stream and instruction-memory write port of the boot controller.
//   load_valid/load_data/load_last : word stream from the host loader
//   load_ready                     : controller takes a word this cycle
//   imem_we/imem_addr/imem_wdata   : one-cycle write strobe into imem
// master = host/loader side, slave = controller side.
interface core_boot_ctrl_if;
  import core_boot_ctrl_pkg::*;

  logic            load_valid;
  logic [XLEN-1:0] load_data;
  logic            load_last;
  logic            load_ready;
  logic            imem_we;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_wdata;

  modport master (
    output load_valid, load_data, load_last,
    input  load_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  load_valid, load_data, load_last,
    output load_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/core_boot_ctrl.sv
// Boot and run sequencer for the single-cycle core. Streams a program into
// instruction memory from address 0 while holding the core in reset, then
// releases it, counts run cycles and optionally halts after a budget.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   start         : pulse; in RUN/HALT restarts the load sequence
//   bus           : loader stream in, imem write port out (slave modport)
//   core_rst      : active-low reset to the core
//   done          : high while halted
//   words_loaded  : words written during the current load
//   cycle_count   : cycles with core_rst=1 since the last load
module core_boot_ctrl
  import core_boot_ctrl_pkg::*;
#(
  parameter  int unsigned WORD_COUNT = 64,
  parameter  int unsigned RUN_CYCLES = 0,
  localparam int unsigned WL_W       = $clog2(WORD_COUNT) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  core_boot_ctrl_if.slave        bus,
  output logic                   core_rst,
  output logic                   done,
  output logic [WL_W-1:0]        words_loaded,
  output logic [XLEN-1:0]        cycle_count
);

  state_e            state_q, state_d;
  logic              load_ready_q, load_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [XLEN-1:0]   imem_addr_q, imem_addr_d;
  logic [XLEN-1:0]   imem_wdata_q, imem_wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic [WL_W-1:0]   words_loaded_q, words_loaded_d;
  logic [XLEN-1:0]   cycle_count_q, cycle_count_d;

  logic              accept_c;
  logic              last_c;
  logic              budget_hit_c;
  logic              restart_c;

  // Next state and registered-output values
  always_comb begin
    state_d        = state_q;
    load_ready_d   = 1'b0;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    core_rst_d     = 1'b0;
    done_d         = 1'b0;
    words_loaded_d = words_loaded_q;
    cycle_count_d  = cycle_count_q;

    accept_c  = (state_q == ST_LOAD) && load_ready_q && bus.load_valid;
    // Filling the last imem slot ends the load even without load_last
    last_c    = bus.load_last || (words_loaded_q == WL_W'(WORD_COUNT - 1));
    // Budget counts only cycles where the core was actually out of reset
    budget_hit_c = (RUN_CYCLES != 0) && core_rst_q &&
                   (cycle_count_q == XLEN'(RUN_CYCLES - 1));
    restart_c = start && ((state_q == ST_RUN) || (state_q == ST_HALT));

    unique case (state_q)
      ST_LOAD:  if (accept_c && last_c) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      ST_RUN: begin
        if (restart_c)         state_d = ST_LOAD;
        else if (budget_hit_c) state_d = ST_HALT;
      end
      ST_HALT:  if (restart_c) state_d = ST_LOAD;
      default:  state_d = ST_LOAD;
    endcase

    load_ready_d = (state_d == ST_LOAD);

    if (accept_c) begin
      imem_we_d      = 1'b1;
      imem_addr_d    = XLEN'(words_loaded_q) * XLEN'(WORD_BYTES);
      imem_wdata_d   = bus.load_data;
      words_loaded_d = words_loaded_q + WL_W'(1);
    end

    // Release lags entry to RUN by one cycle so the FLUSH write settles first
    core_rst_d = (state_q == ST_RUN) && (state_d == ST_RUN);
    done_d     = (state_d == ST_HALT);

    if (restart_c) begin
      words_loaded_d = '0;
      cycle_count_d  = '0;
    end else begin
      cycle_count_d  = cycle_count_q + XLEN'(core_rst_q);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_LOAD;
      load_ready_q   <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      core_rst_q     <= 1'b0;
      done_q         <= 1'b0;
      words_loaded_q <= '0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      load_ready_q   <= load_ready_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      core_rst_q     <= core_rst_d;
      done_q         <= done_d;
      words_loaded_q <= words_loaded_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_rst       = core_rst_q;
  assign done           = done_q;
  assign words_loaded   = words_loaded_q;
  assign cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Bench for core_boot_ctrl: a budgeted small instance (A) and an unbounded
// default instance (B), driven with directed and random programs and checked
// against expected write lists and release/halt timing derived from the
// load/run rules.
module tb_core_boot_ctrl;
  import core_boot_ctrl_pkg::*;

  localparam int unsigned WC_A = 8;
  localparam int unsigned RC_A = 5;
  localparam int unsigned WL_A = $clog2(WC_A) + 1;
  localparam int unsigned WC_B = 64;
  localparam int unsigned WL_B = $clog2(WC_B) + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          at;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_a, start_b;
  logic            core_rst_a, done_a, core_rst_b, done_b;
  logic [WL_A-1:0] words_a;
  logic [WL_B-1:0] words_b;
  logic [XLEN-1:0] ccount_a, ccount_b;

  core_boot_ctrl_if bus_a ();
  core_boot_ctrl_if bus_b ();

  core_boot_ctrl #(.WORD_COUNT(WC_A), .RUN_CYCLES(RC_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(bus_a),
    .core_rst(core_rst_a), .done(done_a),
    .words_loaded(words_a), .cycle_count(ccount_a)
  );

  core_boot_ctrl #(.WORD_COUNT(WC_B), .RUN_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(bus_b),
    .core_rst(core_rst_b), .done(done_b),
    .words_loaded(words_b), .cycle_count(ccount_b)
  );

  always #5 clk = ~clk;

  int          vec = 0;
  int          errs = 0;
  int          cyc = 0;
  wr_t         wq[$];
  int          acc_at[$];
  int          rise_at = -1;
  logic        prev_core_rst = 1'b0;
  logic [31:0] qw[$];
  bit          ql[$];
  int          qg[$];
  int          m_n;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log, release-edge capture and per-cycle invariants on instance A
  always @(negedge clk) begin
    wr_t w;
    if (bus_a.imem_we === 1'b1) begin
      w.addr = bus_a.imem_addr;
      w.data = bus_a.imem_wdata;
      w.at   = cyc;
      wq.push_back(w);
    end
    if (core_rst_a === 1'b1 && prev_core_rst !== 1'b1 && rise_at < 0) rise_at = cyc;
    prev_core_rst = core_rst_a;
    if (rst === 1'b1) begin
      vec++;
      if ((bus_a.imem_we & core_rst_a) !== 1'b0 || bus_a.imem_addr[1:0] !== 2'b00 ||
          bus_a.imem_addr[31:5] !== 27'd0) begin
        errs++;
        $display("FAIL invariant: we=%b core_rst=%b addr=%h, required no overlap, aligned, < 0x20",
                 bus_a.imem_we, core_rst_a, bus_a.imem_addr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_a;
    bus_a.load_valid = 1'b0;
    bus_a.load_last  = 1'b0;
    bus_a.load_data  = '0;
  endtask

  task automatic idle_b;
    bus_b.load_valid = 1'b0;
    bus_b.load_last  = 1'b0;
    bus_b.load_data  = '0;
  endtask

  task automatic clear_prog;
    qw.delete(); ql.delete(); qg.delete();
  endtask

  task automatic push_word(input logic [31:0] w, input bit l, input int g);
    qw.push_back(w); ql.push_back(l); qg.push_back(g);
  endtask

  task automatic wait_ready_a;
    int n = 0;
    while (bus_a.load_ready !== 1'b1 && n < 4) begin step(); n++; end
    vec++;
    if (bus_a.load_ready !== 1'b1) begin
      errs++;
      $display("FAIL ready_timeout: load_ready=%b after %0d cycles, required 1", bus_a.load_ready, n);
    end
  endtask

  // Offer qw/ql with qg idle cycles before each word; words past the program end are held
  task automatic load_a(input bit poke_flush);
    m_n = 0;
    for (int i = 0; i < qw.size(); i++) begin
      m_n = i + 1;
      if (ql[i] || m_n == int'(WC_A)) break;
    end
    wq.delete(); acc_at.delete(); rise_at = -1;
    wait_ready_a();
    for (int i = 0; i < qw.size(); i++) begin
      if (i < m_n) begin
        for (int j = 0; j < qg[i]; j++) begin
          bus_a.load_valid = 1'b0;
          bus_a.load_last  = 1'($urandom_range(1, 0));
          bus_a.load_data  = $urandom;
          step();
        end
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = qw[i];
        bus_a.load_last  = ql[i];
        vec++;
        if (bus_a.load_ready !== 1'b1) begin
          errs++;
          $display("FAIL load_ready word %0d: got %b want 1", i, bus_a.load_ready);
        end
        acc_at.push_back(cyc + 1);
        step();
      end else begin
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = qw[i];
        bus_a.load_last  = 1'b0;
        for (int j = 0; j < 3; j++) begin
          vec++;
          if (bus_a.load_ready !== 1'b0) begin
            errs++;
            $display("FAIL ready_after_end cycle %0d: got %b want 0", j, bus_a.load_ready);
          end
          step();
        end
        break;
      end
    end
    idle_a();
    if (poke_flush && m_n == qw.size()) begin
      start_a = 1'b1;
      step();
      start_a = 1'b0;
    end
  endtask

  task automatic check_load_a;
    int last_acc = (acc_at.size() > 0) ? acc_at[acc_at.size()-1] : cyc;
    while (cyc < last_acc + 3) step();
    vec++;
    if (wq.size() != m_n) begin
      errs++;
      $display("FAIL n_writes: got %0d want %0d", wq.size(), m_n);
    end
    for (int i = 0; i < wq.size() && i < m_n; i++) begin
      vec++;
      if (wq[i].addr !== 32'(4 * i) || wq[i].data !== qw[i] || wq[i].at != acc_at[i]) begin
        errs++;
        $display("FAIL write %0d: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                 i, wq[i].addr, wq[i].data, wq[i].at, 32'(4 * i), qw[i], acc_at[i]);
      end
    end
    vec++;
    if (words_a !== WL_A'(m_n)) begin
      errs++;
      $display("FAIL words_loaded: got %0d want %0d", words_a, m_n);
    end
    vec++;
    if (rise_at != last_acc + 2) begin
      errs++;
      $display("FAIL core_rst_rise: got cycle %0d want %0d", rise_at, last_acc + 2);
    end
  endtask

  // Core out of reset for exactly RC_A cycles, then halted with a frozen count
  task automatic check_run_a;
    if (rise_at < 0) return;
    while (cyc <= rise_at + int'(RC_A) + 2) begin
      int j   = cyc - rise_at;
      bit run = (j < int'(RC_A));
      int cnt = run ? j : int'(RC_A);
      vec++;
      if (core_rst_a !== run || done_a !== !run || ccount_a !== 32'(cnt)) begin
        errs++;
        $display("FAIL run_%0d: got core_rst=%b done=%b count=%0d want %b %b %0d",
                 j, core_rst_a, done_a, ccount_a, run, !run, cnt);
      end
      step();
    end
  endtask

  task automatic restart_a;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    vec++;
    if (core_rst_a !== 1'b0 || done_a !== 1'b0 || ccount_a !== 32'd0 ||
        words_a !== WL_A'(0) || bus_a.load_ready !== 1'b1) begin
      errs++;
      $display("FAIL restart: got core_rst=%b done=%b count=%0d words=%0d ready=%b want 0 0 0 0 1",
               core_rst_a, done_a, ccount_a, words_a, bus_a.load_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    idle_a(); idle_b();
    step(); step();
    vec++;
    if ({bus_a.load_ready, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata,
         core_rst_a, done_a, words_a, ccount_a} !== '0) begin
      errs++;
      $display("FAIL reset_a: got ready=%b we=%b addr=%h wdata=%h core_rst=%b done=%b words=%0d count=%0d want all 0",
               bus_a.load_ready, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata,
               core_rst_a, done_a, words_a, ccount_a);
    end
    vec++;
    if ({bus_b.load_ready, bus_b.imem_we, bus_b.imem_addr, bus_b.imem_wdata,
         core_rst_b, done_b, words_b, ccount_b} !== '0) begin
      errs++;
      $display("FAIL reset_b: outputs not all zero (ready=%b we=%b core_rst=%b count=%0d)",
               bus_b.load_ready, bus_b.imem_we, core_rst_b, ccount_b);
    end
    rst = 1'b1;
    step();
    vec++;
    if (bus_a.load_ready !== 1'b1 || bus_b.load_ready !== 1'b1) begin
      errs++;
      $display("FAIL ready_after_reset: got a=%b b=%b want 1 1", bus_a.load_ready, bus_b.load_ready);
    end
  endtask

  task automatic test_unbounded;
    int n = int'($urandom_range(6, 1));
    int last_acc = 0;
    for (int i = 0; i < n; i++) begin
      bus_b.load_valid = 1'b1;
      bus_b.load_data  = $urandom;
      bus_b.load_last  = (i == n - 1);
      vec++;
      if (bus_b.load_ready !== 1'b1) begin
        errs++;
        $display("FAIL unbounded_ready word %0d: got %b want 1", i, bus_b.load_ready);
      end
      last_acc = cyc + 1;
      step();
    end
    idle_b();
    repeat (40) step();
    vec++;
    if (core_rst_b !== 1'b1 || done_b !== 1'b0 || ccount_b !== 32'(cyc - last_acc - 2) ||
        words_b !== WL_B'(n)) begin
      errs++;
      $display("FAIL unbounded_run: got core_rst=%b done=%b count=%0d words=%0d want 1 0 %0d %0d",
               core_rst_b, done_b, ccount_b, words_b, cyc - last_acc - 2, n);
    end
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    vec++;
    if (core_rst_b !== 1'b0 || done_b !== 1'b0 || ccount_b !== 32'd0 ||
        words_b !== WL_B'(0) || bus_b.load_ready !== 1'b1) begin
      errs++;
      $display("FAIL unbounded_start: got core_rst=%b done=%b count=%0d words=%0d ready=%b want 0 0 0 0 1",
               core_rst_b, done_b, ccount_b, words_b, bus_b.load_ready);
    end
  endtask

  task automatic test_basic;
    clear_prog();
    push_word(32'h00500293, 1'b0, 0);
    push_word(32'h00A00313, 1'b0, 0);
    push_word(32'h006283B3, 1'b0, 0);
    push_word(32'h0000006F, 1'b1, 0);
    load_a(1'b1);
    check_load_a();
    check_run_a();
    restart_a();
  endtask

  task automatic test_gaps;
    clear_prog();
    for (int i = 0; i < 4; i++) push_word($urandom, (i == 3), (i == 2) ? 3 : 0);
    load_a(1'b0);
    check_load_a();
    check_run_a();
    restart_a();
  endtask

  task automatic test_overflow;
    clear_prog();
    for (int i = 0; i < 10; i++) push_word($urandom, 1'b0, 0);
    load_a(1'b0);
    check_load_a();
    check_run_a();
    restart_a();
  endtask

  task automatic test_restart_halt;
    clear_prog();
    for (int i = 0; i < 3; i++) push_word($urandom, (i == 2), 0);
    load_a(1'b0);
    check_load_a();
    check_run_a();
    restart_a();
    clear_prog();
    push_word($urandom, 1'b0, 0);
    push_word($urandom, 1'b1, 0);
    load_a(1'b0);
    check_load_a();
    check_run_a();
    restart_a();
  endtask

  task automatic test_start_at_budget;
    int n = 0;
    clear_prog();
    push_word($urandom, 1'b0, 0);
    push_word($urandom, 1'b1, 0);
    load_a(1'b0);
    check_load_a();
    while (cyc < rise_at + int'(RC_A) - 1 && n < 20) begin step(); n++; end
    vec++;
    if (ccount_a !== 32'(RC_A - 1) || core_rst_a !== 1'b1) begin
      errs++;
      $display("FAIL pre_budget: got count=%0d core_rst=%b want %0d 1", ccount_a, core_rst_a, RC_A - 1);
    end
    restart_a();
    step();
    vec++;
    if (done_a !== 1'b0 || bus_a.load_ready !== 1'b1) begin
      errs++;
      $display("FAIL start_at_budget: got done=%b ready=%b want 0 1", done_a, bus_a.load_ready);
    end
  endtask

  task automatic test_reset_mid_load;
    clear_prog();
    for (int i = 0; i < 4; i++) push_word($urandom, (i == 3), 0);
    wait_ready_a();
    for (int i = 0; i < 2; i++) begin
      bus_a.load_valid = 1'b1;
      bus_a.load_data  = qw[i];
      bus_a.load_last  = 1'b0;
      step();
    end
    idle_a();
    rst = 1'b0;
    step();
    vec++;
    if ({bus_a.load_ready, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata,
         core_rst_a, done_a, words_a, ccount_a} !== '0) begin
      errs++;
      $display("FAIL mid_load_reset: got ready=%b we=%b addr=%h wdata=%h core_rst=%b done=%b words=%0d count=%0d want all 0",
               bus_a.load_ready, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata,
               core_rst_a, done_a, words_a, ccount_a);
    end
    rst = 1'b1;
    clear_prog();
    for (int i = 0; i < 3; i++) push_word($urandom, (i == 2), 0);
    load_a(1'b0);
    check_load_a();
    check_run_a();
    restart_a();
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      int n = int'($urandom_range(10, 1));
      int p = int'($urandom_range(n, 0));
      if (p == n && n < int'(WC_A)) p = n - 1;
      clear_prog();
      for (int i = 0; i < n; i++) push_word($urandom, (i == p), int'($urandom_range(2, 0)));
      load_a(1'($urandom_range(1, 0)));
      check_load_a();
      check_run_a();
      restart_a();
    end
  endtask

  initial begin
    test_reset();
    test_unbounded();
    test_basic();
    test_gaps();
    test_overflow();
    test_restart_halt();
    test_start_at_budget();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/core_boot_ctrl.md
# core_boot_ctrl

Boot and run sequencer for the single-cycle RISC-V core. It accepts a program as a stream of 32-bit words over a valid/ready handshake and writes them into instruction memory from address 0. It holds the core in reset while loading, then releases it and counts run cycles. It halts the core again after an optional cycle budget. It sits between the bench or host loader and `Single_Cycle_Top`, and drives that block's `rst`.

## Interface
- `WORD_COUNT`, default 64: instruction memory depth in words; maximum program length.
- `RUN_CYCLES`, default 0: cycle budget for the core; 0 means unbounded.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse; in RUN or HALT, restarts the load sequence.
- `load_valid`  in  1  loader word valid.
- `load_data`  in  32  instruction word.
- `load_last`  in  1  marks the final word of the program; qualified by `load_valid`.
- `load_ready`  out  1  controller accepts a word this cycle.
- `imem_we`  out  1  instruction memory write strobe, one cycle per word.
- `imem_addr`  out  32  byte address of the write; always word-aligned.
- `imem_wdata`  out  32  write data.
- `core_rst`  out  1  active-low reset to the core; connects to `Single_Cycle_Top.rst`.
- `done`  out  1  high in HALT.
- `words_loaded`  out  $clog2(WORD_COUNT)+1  count of words written this load.
- `cycle_count`  out  32  cycles elapsed with `core_rst`=1 since the last load.

## Operation
- States: LOAD, FLUSH, RUN, HALT.
- Reset (`rst`=0 at an edge): state LOAD. All outputs return to these values: `load_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_rst`=0, `done`=0, `words_loaded`=0, `cycle_count`=0. Instruction memory contents are not cleared.
- LOAD: `load_ready`=1 and `core_rst`=0.
  - A word is accepted when `load_valid` and `load_ready` are both high at an edge. The registered write then appears next cycle: `imem_we`=1, `imem_addr`=`words_loaded`×4 (pre-increment value), `imem_wdata`=`load_data`. `words_loaded` increments.
  - If the accepted word has `load_last`=1, or is word number WORD_COUNT, the next state is FLUSH and `load_ready` drops in the same cycle as the write pulse.
  - Hitting WORD_COUNT without `load_last` terminates the load silently (auto-last).
  - `load_valid` with `load_ready`=0 is ignored; the loader must hold the word.
- FLUSH: exactly one cycle, carrying the last write pulse; then RUN.
- RUN: `core_rst`=1. `cycle_count` increments every cycle.
  - If RUN_CYCLES≠0 and `cycle_count` reaches RUN_CYCLES−1 at an edge, the next state is HALT.
- HALT: `core_rst`=0 and `done`=1. `cycle_count` freezes at RUN_CYCLES.
- `start`: in RUN or HALT, the next state is LOAD. At that edge, `core_rst`=0, `done`=0, `words_loaded`=0 and `cycle_count`=0. `start` is ignored in LOAD and FLUSH.
- `start` coinciding with the RUN→HALT budget edge: `start` wins, and the next state is LOAD.
- `load_last` with `load_valid`=0 has no effect.

## Timing
- Accept-to-write latency is 1 cycle. Sustained throughput is 1 word/cycle.
- Last word accepted at edge k:
  - `imem_we` is high in cycle k+1.
  - `core_rst` rises at edge k+2.
  - The core first fetches from address 0 in the cycle after that.
- `core_rst` never rises in the same cycle as an `imem_we` pulse.
- `imem_addr` upper bits beyond the WORD_COUNT range are always 0. The low 2 bits are always 0.

## Structure
- Shared package holds:
  - the state enumeration (LOAD, FLUSH, RUN, HALT);
  - the constant WORD_BYTES=4;
  - the 32-bit word width shared with the core and memories.
- Single flat module; no sub-module is needed. The two counters and the FSM are small enough to keep inline.

## Test plan
- Load 4 words (0x00500293, 0x00A00313, 0x006283B3, 0x0000006F) with `load_last` on the 4th, 1 word/cycle. Require:
  - writes at 0x0, 0x4, 0x8, 0xC with matching data;
  - `words_loaded`=4;
  - `core_rst` rising 2 cycles after the 4th accept.
- Backpressure and gaps: drop `load_valid` for 3 cycles between words 2 and 3. Require no extra `imem_we` pulses and contiguous addresses.
- Overflow: WORD_COUNT=8 with 10 words offered and no `load_last`. Require:
  - exactly 8 writes, last at 0x1C;
  - `load_ready`=0 after the 8th accept;
  - the core released.
- Budget: RUN_CYCLES=5. Require `core_rst` high for exactly 5 cycles, then `done`=1, `core_rst`=0, `cycle_count`=5.
- Restart:
  - `start` pulse in HALT: require return to LOAD with `done`=0 and `cycle_count`=0, and a second 2-word load writing 0x0 and 0x4.
  - `start` on the budget edge: require LOAD.
- Reset mid-load: assert `rst`=0 after 2 accepted words. Require all outputs at their reset values next cycle, and the first write after release going to 0x0.
